// File: rtl/enc_pkg.sv
// Shared constants and helpers for the 256-to-8 priority encoder pipeline.
package enc_pkg;

    localparam int WORD_W = 256;
    localparam int IDX_W  = 8;
    localparam int GROUPS = 16;
    localparam int GW     = 16;
    localparam int GIDX_W = 4;
    localparam int CNT_W  = 9;

    // True when a population count shows more than one set bit.
    function automatic logic is_multi(input logic [CNT_W-1:0] count);
        return count >= CNT_W'(2);
    endfunction

endpackage

// File: rtl/enc_group16.sv
// Combinational 16-to-4 priority encoder with any-set and multiple-set flags.
module enc_group16
    import enc_pkg::*;
(
    input  logic [GW-1:0]     bits,
    output logic              any,
    output logic [GIDX_W-1:0] idx,
    output logic              mul
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < GW; i++) begin
            if (bits[i]) idx = GIDX_W'(i);
        end
    end

    assign any = |bits;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign mul = |(bits & (bits - GW'(1)));

endmodule

// File: rtl/enc_pipe.sv
// Two-stage pipelined 256-to-8 priority encoder with zero / not-one-hot flags
// and valid/ready handshake on both sides.
module enc_pipe
    import enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W/2-1:0] in0,
    input  logic [WORD_W/2-1:0] in1,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [IDX_W-1:0]    out0,
    output logic                zero,
    output logic                multi,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [WORD_W-1:0]              word;
    logic [GROUPS-1:0]              any_c;
    logic [GROUPS-1:0]              mul_c;
    logic [GROUPS-1:0][GIDX_W-1:0]  idx_c;

    logic                           vld_p1;
    logic [GROUPS-1:0]              any_p1;
    logic [GROUPS-1:0]              mul_p1;
    logic [GROUPS-1:0][GIDX_W-1:0]  idx_p1;
    logic                           vld_p2;

    logic                           s1_advance;
    logic [GIDX_W-1:0]              grp;
    logic [4:0]                     grp_cnt;
    logic [IDX_W-1:0]               out0_c;
    logic                           zero_c;
    logic                           multi_c;

    assign word       = {in1, in0};
    assign s1_advance = ~vld_p2 | out_ready;
    assign in_ready   = ~vld_p1 | s1_advance;
    assign out_valid  = vld_p2;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        enc_group16 u_grp (
            .bits (word[g*GW +: GW]),
            .any  (any_c[g]),
            .idx  (idx_c[g]),
            .mul  (mul_c[g])
        );
    end

    // Stage 1 boundary: per-group summaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready)   vld_p1 <= in_valid;
            if (s1_advance) vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            any_p1 <= any_c;
            mul_p1 <= mul_c;
            idx_p1 <= idx_c;
        end
    end

    always_comb begin
        grp     = '0;
        grp_cnt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (any_p1[g]) begin
                grp     = GIDX_W'(g);
                grp_cnt = grp_cnt + 5'd1;
            end
        end
        zero_c  = ~|any_p1;
        multi_c = (|mul_p1) | is_multi({4'd0, grp_cnt});
        out0_c  = {grp, idx_p1[grp]};
        if (zero_c) begin
            out0_c  = '0;
            multi_c = 1'b0;
        end
    end

    // Stage 2 boundary: group select and final flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0  <= '0;
            zero  <= 1'b0;
            multi <= 1'b0;
        end else if (s1_advance && vld_p1) begin
            out0  <= out0_c;
            zero  <= zero_c;
            multi <= multi_c;
        end
    end

endmodule

// File: tb/tb_enc_pipe.sv
// Scoreboard bench for enc_pipe: vector table, exhaustive one-hot, back-pressure,
// mid-run reset and random streams against an independent bit-level model.
module tb_enc_pipe;
    import enc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in0, in1;
    logic         in_valid, in_ready;
    logic [7:0]   out0;
    logic         zero, multi, out_valid, out_ready;

    enc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .zero      (zero),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] w;
        logic [9:0]   e;
    } vec_t;

    logic [9:0] sb[$];
    logic [9:0] cur_exp;
    logic [9:0] popped;
    int         total = 0;
    int         bad   = 0;
    int         or_mode = 0;
    int         pat_i = 0;
    logic       m1 = 1'b0, m2 = 1'b0;
    logic       m_adv, m_ir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference: scan every bit, no grouping.
    function automatic logic [9:0] ref_enc(input logic [255:0] w);
        int hi = 0;
        int n  = 0;
        for (int i = 0; i < 256; i++) begin
            if (w[i]) begin
                hi = i;
                n++;
            end
        end
        if (n == 0) return {1'b0, 1'b1, 8'h00};
        return {is_multi(CNT_W'(n)), 1'b0, 8'(hi)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m1 = 1'b0;
            m2 = 1'b0;
            sb.delete();
        end else begin
            m_adv = !m2 || out_ready;
            m_ir  = !m1 || m_adv;
            chk("in_ready", in_ready, m_ir);
            chk("out_valid", out_valid, m2);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    popped = sb.pop_front();
                    chk("result", {multi, zero, out0}, popped);
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            m2 = m_adv ? m1 : m2;
            m1 = m_ir ? in_valid : m1;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (pat_i % 3 == 0);
                    pat_i++;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [255:0] w, input logic [9:0] e);
        int   guard = 0;
        logic acc;
        in1      = w[255:128];
        in0      = w[127:0];
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || m1 || m2) && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        vec_t         tbl[8];
        logic [255:0] w;
        int           kind;

        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[8];
        logic [255:0] w;
        int           kind;

        tbl[0] = '{(256'd1 << 255) | 256'd1, {1'b1, 1'b0, 8'hFF}};
        tbl[1] = '{(256'd1 << 17) | (256'd1 << 16), {1'b1, 1'b0, 8'h11}};
        tbl[2] = '{256'd0, {1'b0, 1'b1, 8'h00}};
        tbl[3] = '{256'd1, {1'b0, 1'b0, 8'h00}};
        tbl[4] = '{256'd1 << 255, {1'b0, 1'b0, 8'hFF}};
        tbl[5] = '{~256'd0, {1'b1, 1'b0, 8'hFF}};
        tbl[6] = '{256'd1 << 128, {1'b0, 1'b0, 8'h80}};
        tbl[7] = '{(256'd1 << 127) | (256'd1 << 3), {1'b1, 1'b0, 8'h7F}};

        rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cur_exp = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out0", out0, 0);
        chk("rst_zero", zero, 0);
        chk("rst_multi", multi, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);

        // Latency from an idle pipe
        in1 = '0; in0 = 128'd1 << 5; cur_exp = {2'b00, 8'd5}; in_valid = 1'b1;
        @(negedge clk);
        chk("lat_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 1);
        chk("lat_c2_out0", out0, 5);
        @(posedge clk); #1;
        drain();

        for (int i = 0; i < 8; i++) send(tbl[i].w, tbl[i].e);
        drain();

        for (int k = 0; k < 256; k++) send(256'd1 << k, {2'b00, 8'(k)});
        drain();

        or_mode = 1;
        for (int i = 0; i < 10; i++) begin
            w = 256'd1 << (i * 25 + 3);
            if (i % 3 == 1) w = w | 256'd1;
            send(w, ref_enc(w));
        end
        drain();

        // Fill both stages while stalled, then reset mid-flight
        or_mode = 3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(256'd1 << 200, {2'b00, 8'd200});
        send(256'd1 << 100, {2'b00, 8'd100});
        @(posedge clk); #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out0", out0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        or_mode = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_valid_after", out_valid, 0);
        send(256'd1 << 42, {2'b00, 8'd42});
        drain();

        or_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            kind = $urandom_range(0, 3);
            for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
            case (kind)
                0: w = 256'd1 << $urandom_range(0, 255);
                1: w = (256'd1 << $urandom_range(0, 255)) | (256'd1 << $urandom_range(0, 255));
                2: if ($urandom_range(0, 7) == 0) w = '0;
                default: ;
            endcase
            send(w, ref_enc(w));
        end
        or_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
